// File: rtl/atomik_delta_accum_mc.sv
// Purpose     : multi-channel XOR delta accumulator; state = init ^ acc, with optional per-channel rollback history.
// Latency     : one cycle; state, response register and acc_zero all update on the accepting edge.
// Backpressure: single response register; cmd_ready = !rsp_valid || rsp_ready, so 1 cmd/cycle while rsp_ready is high.
//
// Ports:
//   clk, rst_n              single clock, synchronous active-low reset
//   cmd_valid / cmd_ready   command handshake; cmd_op 00 LOAD, 01 ACCUM, 10 READ, 11 ROLLBACK
//   cmd_ch, cmd_data        target channel, LOAD value / ACCUM delta
//   rsp_valid / rsp_ready   response handshake; exactly one response per accepted command
//   rsp_ch, rsp_data        channel and its state after the command
//   rsp_err                 command rejected (bad channel, or nothing to roll back); no state changed
//   acc_zero                registered, bit i set when channel i's accumulator is zero
//
// Build option: define ATOMIK_DELTA_HISTORY_EN to build the per-channel delta history
// (multi-level ROLLBACK). Without it, ROLLBACK always answers with rsp_err and the current state.

module atomik_delta_accum_mc #(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_CH     = 4,
    parameter  int HIST_DEPTH = 8,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic [DATA_WIDTH-1:0] cmd_data,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [CH_W-1:0]       rsp_ch,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,

    output logic [NUM_CH-1:0]     acc_zero
);

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_ACCUM    = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] OP_ROLLBACK = 2'b11;

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DATA_WIDTH-1:0] dat;
        logic                  err;
    } rsp_t;

    // ------------------------------------------------------------------
    // Channel state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] init_q [NUM_CH];
    logic [DATA_WIDTH-1:0] acc_q  [NUM_CH];
    logic [NUM_CH-1:0]     acc_zero_q;

    rsp_t rsp_q;
    logic rsp_vld_q;

    logic cmd_fire;
    logic ch_ok;

    assign cmd_ready = !rsp_vld_q || rsp_ready;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Channel numbers beyond NUM_CH are possible when NUM_CH is not a power of two.
    assign ch_ok = (32'(cmd_ch) < NUM_CH);

    // Selected-channel view. Built as a compare-mux rather than a direct
    // index so an out-of-range cmd_ch never reads past the arrays.
    logic [DATA_WIDTH-1:0] sel_init;
    logic [DATA_WIDTH-1:0] sel_acc;
    logic [DATA_WIDTH-1:0] cur_state;

    always_comb begin
        sel_init = '0;
        sel_acc  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ok && (cmd_ch == CH_W'(i))) begin
                sel_init = init_q[i];
                sel_acc  = acc_q[i];
            end
        end
    end

    assign cur_state = sel_init ^ sel_acc;

    // ------------------------------------------------------------------
    // Delta history: rollback availability and the delta that would be popped
    // ------------------------------------------------------------------
    logic                  pop_ok;   // selected channel has an undoable delta
    logic [DATA_WIDTH-1:0] pop_dat;  // most recent delta of the selected channel

`ifdef ATOMIK_DELTA_HISTORY_EN
    localparam int HW = $clog2(HIST_DEPTH);
    localparam int CW = HW + 1;   // count spans 0..HIST_DEPTH inclusive

    logic [DATA_WIDTH-1:0] hist_q [NUM_CH][HIST_DEPTH];
    logic [HW-1:0]         wp_q   [NUM_CH];
    logic [CW-1:0]         cnt_q  [NUM_CH];

    always_comb begin
        pop_ok  = 1'b0;
        pop_dat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ok && (cmd_ch == CH_W'(i))) begin
                pop_ok  = (cnt_q[i] != '0);
                pop_dat = hist_q[i][HW'(wp_q[i] - 1'b1)];
            end
        end
    end

    // Pointer and count. wp wraps naturally because HIST_DEPTH is a power of
    // two; once full, a push overwrites the oldest entry and count saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wp_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else if (cmd_fire && ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmd_ch == CH_W'(i)) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            wp_q[i]  <= '0;
                            cnt_q[i] <= '0;
                        end
                        OP_ACCUM: begin
                            wp_q[i] <= HW'(wp_q[i] + 1'b1);
                            if (cnt_q[i] != CW'(HIST_DEPTH)) begin
                                cnt_q[i] <= CW'(cnt_q[i] + 1'b1);
                            end
                        end
                        OP_ROLLBACK: begin
                            if (cnt_q[i] != '0) begin
                                wp_q[i]  <= HW'(wp_q[i] - 1'b1);
                                cnt_q[i] <= CW'(cnt_q[i] - 1'b1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // History storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (rst_n && cmd_fire && ch_ok && (cmd_op == OP_ACCUM)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmd_ch == CH_W'(i)) begin
                    hist_q[i][wp_q[i]] <= cmd_data;
                end
            end
        end
    end
`else
    // No history storage: nothing is ever undoable.
    assign pop_ok  = 1'b0;
    assign pop_dat = '0;
`endif

    // ------------------------------------------------------------------
    // Command decode: next channel state and response
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] nxt_init;
    logic [DATA_WIDTH-1:0] nxt_acc;
    logic                  st_we;
    rsp_t                  rsp_n;

    always_comb begin
        nxt_init  = sel_init;
        nxt_acc   = sel_acc;
        st_we     = 1'b0;
        rsp_n.ch  = cmd_ch;
        rsp_n.dat = '0;
        rsp_n.err = 1'b0;

        if (!ch_ok) begin
            rsp_n.err = 1'b1;
        end else begin
            case (cmd_op)
                OP_LOAD: begin
                    nxt_init  = cmd_data;
                    nxt_acc   = '0;
                    st_we     = 1'b1;
                    rsp_n.dat = cmd_data;
                end
                OP_ACCUM: begin
                    nxt_acc   = sel_acc ^ cmd_data;
                    st_we     = 1'b1;
                    rsp_n.dat = sel_init ^ (sel_acc ^ cmd_data);
                end
                OP_READ: begin
                    rsp_n.dat = cur_state;
                end
                OP_ROLLBACK: begin
                    if (pop_ok) begin
                        nxt_acc   = sel_acc ^ pop_dat;
                        st_we     = 1'b1;
                        rsp_n.dat = sel_init ^ (sel_acc ^ pop_dat);
                    end else begin
                        rsp_n.err = 1'b1;
                        rsp_n.dat = cur_state;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, acc_zero and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                init_q[i] <= '0;
                acc_q[i]  <= '0;
            end
            acc_zero_q <= '1;
            rsp_q      <= '0;
            rsp_vld_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                rsp_q     <= rsp_n;
                rsp_vld_q <= 1'b1;
            end else if (rsp_ready) begin
                rsp_vld_q <= 1'b0;
            end

            if (cmd_fire && st_we) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cmd_ch == CH_W'(i)) begin
                        init_q[i]     <= nxt_init;
                        acc_q[i]      <= nxt_acc;
                        acc_zero_q[i] <= (nxt_acc == '0);
                    end
                end
            end
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_ch    = rsp_q.ch;
    assign rsp_data  = rsp_q.dat;
    assign rsp_err   = rsp_q.err;
    assign acc_zero  = acc_zero_q;

endmodule

// File: tb/tb_atomik_delta_accum_mc.sv
// Purpose     : self-checking bench for atomik_delta_accum_mc (directed table, handshake corners, random vs model).
// Latency     : response expected one edge after the accepting edge.
// Backpressure: exercised by holding rsp_ready low across accepts and mid-transaction reset.

module tb_atomik_delta_accum_mc;

    localparam int DW  = 64;
    localparam int NCH = 4;
    localparam int HD  = 8;

`ifdef ATOMIK_DELTA_HISTORY_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    localparam logic [1:0] LOAD = 2'b00, ACCUM = 2'b01, READ = 2'b10, RB = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_ch;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_ch;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [NCH-1:0] acc_zero;

    always #5 clk = ~clk;

    atomik_delta_accum_mc #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .HIST_DEPTH (HD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ch    (cmd_ch),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ch    (rsp_ch),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .acc_zero  (acc_zero)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: state per channel plus an undo stack per channel
    // that forgets its oldest entry beyond HD deltas.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_init [NCH];
    logic [DW-1:0] m_acc  [NCH];
    logic [DW-1:0] m_hist [NCH][$];

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_init[c] = '0;
            m_acc[c]  = '0;
            m_hist[c].delete();
        end
    endfunction

    function automatic logic [NCH-1:0] m_zero();
        logic [NCH-1:0] z;
        for (int c = 0; c < NCH; c++) z[c] = (m_acc[c] == '0);
        return z;
    endfunction

    function automatic void model_step(input logic [1:0] op, input int ch, input logic [DW-1:0] d,
                                       output logic [DW-1:0] ed, output logic ee);
        ee = 1'b0;
        ed = '0;
        case (op)
            LOAD: begin
                m_init[ch] = d;
                m_acc[ch]  = '0;
                m_hist[ch].delete();
                ed = d;
            end
            ACCUM: begin
                m_acc[ch] = m_acc[ch] ^ d;
                m_hist[ch].push_back(d);
                if (m_hist[ch].size() > HD) void'(m_hist[ch].pop_front());
                ed = m_init[ch] ^ m_acc[ch];
            end
            READ: ed = m_init[ch] ^ m_acc[ch];
            default: begin
                if (HIST_ON && (m_hist[ch].size() > 0)) begin
                    m_acc[ch] = m_acc[ch] ^ m_hist[ch].pop_back();
                end else begin
                    ee = 1'b1;
                end
                ed = m_init[ch] ^ m_acc[ch];
            end
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Drive / check helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [1:0] op, input int ch, input logic [DW-1:0] d);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = 2'(ch);
        cmd_data  = d;
        rsp_ready = 1'b1;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, waited);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string name, input logic [DW-1:0] ed, input logic ee,
                             input logic [1:0] ech, input logic [NCH-1:0] ez);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== ee || rsp_ch !== ech || acc_zero !== ez) begin
            n_fail++;
            $display("FAIL %s: got vld=%0b data=%h err=%0b ch=%0d zero=%b, required vld=1 data=%h err=%0b ch=%0d zero=%b",
                     name, rsp_valid, rsp_data, rsp_err, rsp_ch, acc_zero, ed, ee, ech, ez);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic check_reset_state(input string name);
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0 || rsp_ch !== 2'd0 ||
            acc_zero !== 4'b1111 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got vld=%0b data=%h err=%0b ch=%0d zero=%b rdy=%0b, required 0/0/0/0/1111/1",
                     name, rsp_valid, rsp_data, rsp_err, rsp_ch, acc_zero, cmd_ready);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]     op;
        int             ch;
        logic [DW-1:0]  data;
        logic [DW-1:0]  exp_d;
        logic           exp_e;
        logic [NCH-1:0] exp_z;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] op, input int ch, input logic [DW-1:0] d,
                                input logic [DW-1:0] ed, input logic ee, input logic [NCH-1:0] ez);
        vec_t v;
        v.op = op; v.ch = ch; v.data = d; v.exp_d = ed; v.exp_e = ee; v.exp_z = ez;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] md, a5, kk, bit_i, st;
        logic          me;
        logic [NCH-1:0] z_ovf;
        int            ch, opr;
        logic [1:0]    op;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ch = '0; cmd_data = '0; rsp_ready = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        kk = 64'h1234567890ABCDEF;
        a5 = 64'h5555555555555555;
        add(READ,  0, '0,                    '0,                    1'b0, 4'b1111);
        add(LOAD,  1, 64'hAAAAAAAAAAAAAAAA,  64'hAAAAAAAAAAAAAAAA,  1'b0, 4'b1111);
        add(ACCUM, 1, a5,                    64'hFFFFFFFFFFFFFFFF,  1'b0, 4'b1101);
        add(READ,  1, '0,                    64'hFFFFFFFFFFFFFFFF,  1'b0, 4'b1101);
        add(ACCUM, 2, kk,                    kk,                    1'b0, 4'b1001);
        add(ACCUM, 2, kk,                    '0,                    1'b0, 4'b1101);
        add(READ,  1, '0,                    64'hFFFFFFFFFFFFFFFF,  1'b0, 4'b1101);
        add(LOAD,  0, '0,                    '0,                    1'b0, 4'b1101);
        add(ACCUM, 0, 64'h1,                 64'h1,                 1'b0, 4'b1100);
        add(ACCUM, 0, 64'h2,                 64'h3,                 1'b0, 4'b1100);
        add(ACCUM, 0, 64'h4,                 64'h7,                 1'b0, 4'b1100);
        add(RB,    0, '0, HIST_ON ? 64'h3 : 64'h7, !HIST_ON, 4'b1100);
        add(RB,    0, '0, HIST_ON ? 64'h1 : 64'h7, !HIST_ON, 4'b1100);
        add(RB,    0, '0, HIST_ON ? 64'h0 : 64'h7, !HIST_ON, HIST_ON ? 4'b1101 : 4'b1100);
        add(RB,    0, '0, HIST_ON ? 64'h0 : 64'h7, 1'b1,     HIST_ON ? 4'b1101 : 4'b1100);
        // History overflow on ch3: nine pushes into an eight-deep history.
        z_ovf = HIST_ON ? 4'b0101 : 4'b0100;
        st = '0;
        for (int i = 0; i <= 8; i++) begin
            bit_i = 64'd1 << i;
            st    = st | bit_i;
            add(ACCUM, 3, bit_i, st, 1'b0, z_ovf);
        end
        for (int k = 1; k <= 8; k++) begin
            add(RB, 3, '0, HIST_ON ? (64'h1FF >> k) : 64'h1FF, !HIST_ON, z_ovf);
        end
        add(RB, 3, '0, HIST_ON ? 64'h1 : 64'h1FF, 1'b1, z_ovf);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].op, vecs[i].ch, vecs[i].data);
            model_step(vecs[i].op, vecs[i].ch, vecs[i].data, md, me);
            check_rsp($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_e, 2'(vecs[i].ch), vecs[i].exp_z);
        end

        // Backpressure: first drain the held response, then stall one.
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        check_bit("drain_rsp_valid", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_op = READ; cmd_ch = 2'd1; cmd_data = '0;
        @(posedge clk); #1;
        model_step(READ, 1, '0, md, me);
        check_rsp("bp_first", md, me, 2'd1, m_zero());
        check_bit("bp_ready_low", cmd_ready, 1'b0);
        cmd_op = ACCUM; cmd_ch = 2'd0; cmd_data = 64'h10;
        @(posedge clk); #1;
        check_rsp("bp_first_held", md, me, 2'd1, m_zero());
        check_bit("bp_ready_still_low", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        #1;
        check_bit("bp_ready_follows", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_step(ACCUM, 0, 64'h10, md, me);
        check_rsp("bp_second", md, me, 2'd0, m_zero());

        // Reset while a response is pending drops it and clears all state.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = LOAD; cmd_ch = 2'd2; cmd_data = 64'hDEAD;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_state("mid_reset");
        m_reset();
        rst_n = 1'b1;
        send(READ, 2, '0);
        model_step(READ, 2, '0, md, me);
        check_rsp("post_reset_read", md, me, 2'd2, m_zero());

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            opr = $urandom_range(0, 9);
            op  = (opr == 0) ? LOAD : (opr <= 4) ? ACCUM : (opr == 5) ? READ : RB;
            ch  = $urandom_range(0, NCH - 1);
            md  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) md = 64'($urandom_range(0, 15));
            send(op, ch, md);
            model_step(op, ch, md, md, me);
            check_rsp($sformatf("rand%0d", n), md, me, 2'(ch), m_zero());
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/atomik_delta_accum_mc.md
# atomik_delta_accum_mc

Multi-channel ATOMiK delta accumulator with multi-level rollback history; parametrised successor to the single-channel edge-sensor accumulator. Each channel holds an initial state and an XOR delta accumulator. Current state is always initial XOR accumulator. Commands enter through a valid/ready command port and every accepted command produces exactly one response. Sits between the sensor-fusion front end (delta producers) and state consumers.

## Interface
- DATA_WIDTH, 64, width of state, delta and response data
- NUM_CH, 4, number of independent channels (≥1)
- HIST_DEPTH, 8, per-channel delta history entries; power of two, ≥2
- CH_W, derived as max(1, $clog2(NUM_CH)); not overridden
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 LOAD, 01 ACCUM, 10 READ, 11 ROLLBACK
- cmd_ch  in  CH_W  target channel
- cmd_data  in  DATA_WIDTH  LOAD value or ACCUM delta; ignored otherwise
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_ch  out  CH_W  channel of the response
- rsp_data  out  DATA_WIDTH  channel state after the command
- rsp_err  out  1  command rejected, no state changed
- acc_zero  out  NUM_CH  bit i = (acc[i] == 0)

## Operation
- LOAD: init[ch] ← cmd_data; acc[ch] ← 0; history[ch] cleared (count 0). rsp_data = cmd_data.
- ACCUM: acc[ch] ← acc[ch] ^ cmd_data; delta pushed to history[ch]. rsp_data = init ^ new acc.
- READ: no state change. rsp_data = init ^ acc.
- ROLLBACK: if count[ch] > 0: the most recent delta is popped, acc[ch] ← acc[ch] ^ popped, count decremented, rsp_data = new state. If count[ch] == 0: rsp_err = 1, rsp_data = current state, nothing changes.
- History: per-channel circular LIFO with write pointer wp and count. Push writes buf[wp], wp ← wp+1 mod HIST_DEPTH, count ← min(count+1, HIST_DEPTH). When full, a push overwrites the oldest entry; that entry is no longer undoable. Pop reads buf[wp−1], wp ← wp−1 mod HIST_DEPTH.
- cmd_ch ≥ NUM_CH: rsp_err = 1, rsp_data = 0, rsp_ch = cmd_ch, no state change.
- Channels are fully isolated; a command never alters another channel's init, acc, history or acc_zero bit.
- All XOR arithmetic is bitwise at DATA_WIDTH; no carries, no saturation.

## Timing
- Reset (rst_n low at a rising edge): all init, acc, wp and count set to 0; rsp_valid 0, rsp_data 0, rsp_ch 0, rsp_err 0; acc_zero all ones; cmd_ready 1. Reset mid-transaction drops any pending response.
- cmd_ready = !rsp_valid || rsp_ready (combinational; single response register).
- Latency: command accepted at edge N. State update and response register loaded at the same edge. rsp_valid is high after edge N and holds, with stable fields, until consumed.
- Throughput: 1 command/cycle when rsp_ready is held high.
- acc_zero is registered and reflects the state after edge N, coincident with the response.
- Back-to-back commands to the same channel see the previous command's update; there are no hazards.

## Configuration
- ATOMIK_DELTA_HISTORY_EN defined: history buffers built as above; multi-level ROLLBACK supported.
- Not defined: no history storage. ROLLBACK always returns rsp_err = 1 with the current state, and acc is unchanged. All other commands are identical.

## Test plan
- Reset, then READ ch0 → rsp_data 0, rsp_err 0, acc_zero 4'b1111, cmd_ready 1.
- LOAD ch1 0xAAAAAAAAAAAAAAAA, then ACCUM ch1 0x5555555555555555 → rsp_data 0xFFFFFFFFFFFFFFFF. READ ch1 → same value. acc_zero 4'b1101.
- ACCUM ch2 0x1234567890ABCDEF twice → second rsp_data 0, acc_zero[2] back to 1. Ch1 is unchanged on READ.
- LOAD ch0 0; ACCUM 0x1, 0x2, 0x4; ROLLBACK ×3 → rsp_data 0x3, 0x1, 0x0. A fourth ROLLBACK → rsp_err 1, rsp_data 0.
- Overflow (HIST_DEPTH 8): ACCUM ch3 with 1<<i for i = 0..8 → state 0x1FF. 8 ROLLBACKs end at 0x001; the 9th → rsp_err 1.
- Backpressure: hold rsp_ready 0 after one accept → cmd_ready 0 and a second command is held. Raise rsp_ready → the first response is consumed and the second is accepted in the same cycle. The macro-off build: ROLLBACK → rsp_err 1.
